// File: rtl/chanlink_pkg.sv
// Shared constants, state encoding and descriptor layout for the channel-link event builder.
package chanlink_pkg;

   localparam int NCHIP   = 6;
   localparam int NCHAN   = 16;
   localparam int SAMP_AW = 9;
   localparam int EVT_DW  = 37;
   localparam int WD_W    = 18;
   localparam int CHIP_W  = 3;
   localparam int CHAN_W  = 4;
   localparam int SMAX_W  = 7;
   localparam int NUM_W   = 24;
   localparam int BXN_W   = 12;

   localparam int EVT_BXN_LSB  = 0;
   localparam int EVT_NUM_LSB  = 12;
   localparam int EVT_OVLP_BIT = 36;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_READ = 2'd2,
      ST_TAIL = 2'd3
   } state_t;

   typedef struct packed {
      logic [NUM_W-1:0]   num;
      logic [BXN_W-1:0]   bxn;
      logic [SAMP_AW-1:0] ptr;
      logic               ovlp;
   } l1a_entry_t;

   function automatic logic [EVT_DW-1:0] make_desc(input l1a_entry_t e);
      logic [EVT_DW-1:0] d;
      d = '0;
      d[EVT_OVLP_BIT]            = e.ovlp;
      d[EVT_NUM_LSB +: NUM_W]    = e.num;
      d[EVT_BXN_LSB +: BXN_W]    = e.bxn;
      return d;
   endfunction

endpackage

// File: rtl/chanlink_evt_builder_l1a_queue.sv
// First-word fall-through queue of pending L1A entries; a push while full is ignored.
module l1a_queue
   import chanlink_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic       WCLK,
   input  logic       FIFO_RST,
   input  logic       push,
   input  logic       pop,
   input  l1a_entry_t din,
   output l1a_entry_t dout,
   output logic       empty,
   output logic       full
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   l1a_entry_t    mem [QDEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(QDEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge WCLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge WCLK or posedge FIFO_RST) begin
      if (FIFO_RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(QDEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(QDEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/chanlink_evt_builder.sv
// Builds one descriptor plus a chip/channel/sample stream of flagged words per queued L1A.
module chanlink_evt_builder #(
   parameter int QDEPTH = 4,
   parameter int NCHIP  = chanlink_pkg::NCHIP,
   parameter int NCHAN  = chanlink_pkg::NCHAN
) (
   input  logic        WCLK,
   input  logic        FIFO_RST,
   input  logic        L1A,
   input  logic [23:0] L1A_NUM,
   input  logic [11:0] BXN,
   input  logic [8:0]  L1A_PTR,
   input  logic [6:0]  SAMP_MAX,
   input  logic        PAUSE,
   output logic        SMP_RDEN,
   output logic [15:0] SMP_RADDR,
   input  logic [15:0] SMP_RDATA,
   output logic        L1A_WRT_EN,
   output logic [36:0] L1A_EVT_DATA,
   output logic        WREN,
   output logic [17:0] WDATA,
   output logic        BUSY,
   output logic        L1A_OVF
);

   import chanlink_pkg::*;

   state_t             state;
   l1a_entry_t         q_din;
   l1a_entry_t         q_dout;
   l1a_entry_t         cur;
   logic               q_empty;
   logic               q_full;
   logic               q_pop;
   logic [SMAX_W-1:0]  smax;
   logic [CHIP_W-1:0]  chip;
   logic [CHAN_W-1:0]  chan;
   logic [SMAX_W-1:0]  samp;
   logic [SAMP_AW-1:0] samp_addr;
   logic               rd_en;
   logic               rd_first;
   logic               rd_last;
   logic               wrt_en;
   logic               busy;
   logic               ovf;
   logic               vld_p1;
   logic               first_p1;
   logic               last_p1;

   // An L1A overlaps when anything is in flight or already waiting.
   assign q_din = '{num: L1A_NUM, bxn: BXN, ptr: L1A_PTR, ovlp: busy | !q_empty};
   assign q_pop = (state == ST_IDLE) && !q_empty;

   l1a_queue #(.QDEPTH(QDEPTH)) u_queue (
      .WCLK     (WCLK),
      .FIFO_RST (FIFO_RST),
      .push     (L1A),
      .pop      (q_pop),
      .din      (q_din),
      .dout     (q_dout),
      .empty    (q_empty),
      .full     (q_full)
   );

   assign rd_en     = (state == ST_READ) && !PAUSE;
   assign rd_first  = (chip == '0) && (chan == '0) && (samp == '0);
   assign rd_last   = (chip == CHIP_W'(NCHIP-1)) && (chan == CHAN_W'(NCHAN-1)) && (samp == smax);
   assign samp_addr = cur.ptr + SAMP_AW'(samp);

   always_ff @(posedge WCLK or posedge FIFO_RST) begin
      if (FIFO_RST) begin
         state  <= ST_IDLE;
         cur    <= '0;
         smax   <= '0;
         chip   <= '0;
         chan   <= '0;
         samp   <= '0;
         wrt_en <= 1'b0;
         busy   <= 1'b0;
      end else begin
         wrt_en <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!q_empty) begin
                  cur    <= q_dout;
                  smax   <= SAMP_MAX;
                  chip   <= '0;
                  chan   <= '0;
                  samp   <= '0;
                  wrt_en <= 1'b1;
                  busy   <= 1'b1;
                  state  <= ST_HDR;
               end
            end
            ST_HDR: state <= ST_READ;
            ST_READ: begin
               if (rd_en) begin
                  if (rd_last) state <= ST_TAIL;
                  if (samp == smax) begin
                     samp <= '0;
                     if (chan == CHAN_W'(NCHAN-1)) begin
                        chan <= '0;
                        chip <= chip + 1'b1;
                     end else begin
                        chan <= chan + 1'b1;
                     end
                  end else begin
                     samp <= samp + 1'b1;
                  end
               end
            end
            ST_TAIL: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // p1: read data returns one cycle after the enable, flags travel with it
   always_ff @(posedge WCLK or posedge FIFO_RST) begin
      if (FIFO_RST) begin
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         vld_p1   <= rd_en;
         first_p1 <= rd_en && rd_first;
         last_p1  <= rd_en && rd_last;
         ovf      <= ovf | (L1A & q_full);
      end
   end

   assign SMP_RDEN     = rd_en;
   assign SMP_RADDR    = {chip, chan, samp_addr};
   assign L1A_WRT_EN   = wrt_en;
   assign L1A_EVT_DATA = make_desc(cur);
   assign WREN         = vld_p1;
   assign WDATA        = vld_p1 ? {last_p1, first_p1, SMP_RDATA} : '0;
   assign BUSY         = busy;
   assign L1A_OVF      = ovf;

endmodule
